sha1_channel_dispatch: RTL
==========================

// Module: sha1_channel_dispatch
// PURPOSE
//  Consumer end of the free-channel-ID list kept by the SHA1 channel controller. Pops a free
//  channel ID per incoming job, starts that SHA1 channel, tracks in-flight jobs, round-robin
//  collects channel completions and returns each finished ID to the free list (result_valid/data_sq_tmp).
// PARAMETERS
//  CHANNEL_NUM_TOTAL  64                          number of SHA1 channels (power of 2)
//  CHANNEL_NUM_WIDTH  $clog2(CHANNEL_NUM_TOTAL)   channel ID width (CW)
//  TAG_W              16                          job tag width, carried job -> result
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       synchronous, active-low reset
//  job_valid    in   1       job request
//  job_tag      in   TAG_W   job tag
//  job_ready    out  1       job accepted when job_valid&job_ready (comb)
//  free_empty   in   1       free-ID FIFO empty (FWFT)
//  free_id      in   CW      free-ID FIFO head
//  free_rd_en   out  1       free-ID FIFO pop (comb)
//  ch_start     out  N       one-hot start pulse to channel
//  ch_tag       out  TAG_W   tag broadcast, valid with ch_start
//  ch_done      in   N       per-channel done level, held until acked
//  ch_done_ack  out  N       one-hot ack pulse
//  rls_valid    out  1       ID-release pulse to free list (-> result_valid)
//  rls_id       out  CW      released ID (-> data_sq_tmp)
//  res_valid    out  1       result available
//  res_ready    in   1       result consumer ready
//  res_tag      out  TAG_W   tag of finished job
//  res_ch       out  CW      channel of finished job
//  busy_cnt     out  CW+1    jobs in flight
//  err          out  2       sticky: [0] dispatch to busy ID, [1] done from idle channel
// BEHAVIOUR
//  Reset: all outputs 0, busy bitmap 0, busy_cnt 0, RR pointer 0, tag memory contents don't-care.
//  Dispatch: job_ready = ~free_empty; fire = job_valid & job_ready; free_rd_en = fire.
//   Cycle after fire: ch_start[free_id]=1 for one cycle, ch_tag=job_tag, busy[free_id]=1,
//   tag_mem[free_id]=job_tag. Back-to-back fires every cycle allowed. Latency fire->start = 1.
//   fire with busy[free_id] already 1 -> err[0] set; job still dispatched.
//  While free list initialises, free_empty is high, so no job is accepted.
//  Completion FSM (C_IDLE, C_RESP):
//   C_IDLE: pend = ch_done & busy; if pend!=0, grant g = first set bit at/after RR pointer
//    (wrap), latch g, -> C_RESP.
//   C_RESP: res_valid=1, res_ch=g, res_tag=tag_mem[g]; hold stable until res_ready.
//    On res_valid&res_ready: ch_done_ack[g] pulse, busy[g]<=0, rls_valid pulse with rls_id=g,
//    RR pointer <= g+1 (mod N), -> C_IDLE. Throughput: one completion per 2 cycles.
//  busy_cnt: +1 on fire, -1 on completion handshake, both in same cycle -> unchanged;
//   never exceeds N.
//  Same-cycle dispatch to ID x and completion of x cannot occur (x not yet released);
//   fire and completion handshake on different IDs both take effect.
//  ch_done on channel with busy=0 -> ignored for arbitration, err[1] set.
//  Reset mid-operation: all in-flight jobs dropped, no ack/rls issued; free list rebuilt by
//   its own reset.
// STRUCTURE
//  Package sha1_pkg: CHANNEL_NUM_TOTAL default, TAG_W default, completion-state enum.
//  Sub-module sha1_rr_arb: N-way round-robin priority pick (req, ptr -> grant idx, any).
//  Tag memory: N x TAG_W register array (distributed RAM inferred).
// TESTING
//  Bench instantiates with the channel controller FIFO and behavioural channel models.
//  Startup: job_valid=1 from reset -> job_ready low until free list filled; first start on ch 0.
//  Burst: 64 jobs tags 0..63 back-to-back -> ch_start ch0..63 one per cycle, busy_cnt=64,
//   job_ready=0 on 65th.
//  Simultaneous done on ch 5,9,2 with ptr=6 -> results in order 9,2,5; rls_id same order.
//  Backpressure: res_ready low 10 cycles -> res_valid/res_tag/res_ch stable, no ack/rls pulse.
//  Released ID reuse: complete ch 3 while full -> next job dispatched to ch 3 with new tag.
//  Errors: force ch_done[7] on idle ch -> err[1]=1, no result; rst_n low mid-burst -> busy_cnt=0.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared defaults and the completion-state encoding for the SHA1 channel dispatcher.
package sha1_pkg;

  localparam int unsigned CHANNEL_NUM_TOTAL_DEF = 64;
  localparam int unsigned TAG_W_DEF             = 16;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_RESP = 1'b1
  } cstate_e;

endpackage

// File: rtl/sha1_rr_arb.sv
// N-way round-robin pick: first set request at or after ptr, wrapping modulo N.
module sha1_rr_arb #(
  parameter int unsigned N = 64,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] cand;

  // N is a power of two, so the W-bit add wraps the search naturally.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = ptr + W'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/sha1_channel_dispatch.sv
// Pops free channel IDs per job, starts channels, and round-robin returns
// finished channels to the free list along with their job tag.
module sha1_channel_dispatch
  import sha1_pkg::*;
#(
  parameter int unsigned CHANNEL_NUM_TOTAL = CHANNEL_NUM_TOTAL_DEF,
  parameter int unsigned CHANNEL_NUM_WIDTH = $clog2(CHANNEL_NUM_TOTAL),
  parameter int unsigned TAG_W             = TAG_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         job_valid,
  input  logic [TAG_W-1:0]             job_tag,
  output logic                         job_ready,
  input  logic                         free_empty,
  input  logic [CHANNEL_NUM_WIDTH-1:0] free_id,
  output logic                         free_rd_en,
  output logic [CHANNEL_NUM_TOTAL-1:0] ch_start,
  output logic [TAG_W-1:0]             ch_tag,
  input  logic [CHANNEL_NUM_TOTAL-1:0] ch_done,
  output logic [CHANNEL_NUM_TOTAL-1:0] ch_done_ack,
  output logic                         rls_valid,
  output logic [CHANNEL_NUM_WIDTH-1:0] rls_id,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [TAG_W-1:0]             res_tag,
  output logic [CHANNEL_NUM_WIDTH-1:0] res_ch,
  output logic [CHANNEL_NUM_WIDTH:0]   busy_cnt,
  output logic [1:0]                   err
);

  localparam int unsigned N    = CHANNEL_NUM_TOTAL;
  localparam int unsigned CW   = CHANNEL_NUM_WIDTH;
  localparam int unsigned CNTW = CW + 1;

  cstate_e         state_q, state_d;
  logic [CW-1:0]   g_q, g_d, ptr_q, ptr_d, arb_idx;
  logic            arb_any, fire, hs;
  logic [N-1:0]    busy_q, busy_d, start_q, start_d, pend;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] tag_mem_q [N];
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [1:0]      err_q, err_d;

  assign job_ready  = ~free_empty;
  assign fire       = job_valid & ~free_empty;
  assign free_rd_en = fire;
  assign pend       = ch_done & busy_q;

  sha1_rr_arb #(.N(N), .W(CW)) u_arb (
    .req (pend),
    .ptr (ptr_q),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    hs        = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      C_IDLE: begin
        if (arb_any) begin
          g_d     = arb_idx;
          state_d = C_RESP;
        end
      end
      C_RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          hs      = 1'b1;
          ptr_d   = g_q + CW'(1);
          state_d = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  assign res_ch      = res_valid ? g_q : '0;
  assign res_tag     = res_valid ? tag_mem_q[g_q] : '0;
  assign rls_valid   = hs;
  assign rls_id      = hs ? g_q : '0;
  assign ch_done_ack = hs ? (N'(1) << g_q) : '0;
  assign ch_start    = start_q;
  assign ch_tag      = tag_q;
  assign busy_cnt    = cnt_q;
  assign err         = err_q;

  // A release and a dispatch in the same cycle always target different IDs.
  always_comb begin
    busy_d = busy_q;
    if (hs)   busy_d[g_q]     = 1'b0;
    if (fire) busy_d[free_id] = 1'b1;
    start_d = fire ? (N'(1) << free_id) : '0;
    tag_d   = fire ? job_tag : tag_q;
    cnt_d   = cnt_q + CNTW'(fire) - CNTW'(hs);
    err_d   = err_q | {|(ch_done & ~busy_q), fire & busy_q[free_id]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= C_IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      busy_q  <= '0;
      start_q <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) tag_mem_q[free_id] <= job_tag;
  end

endmodule
